// File: rtl/mio_bus_n_if.sv
// mio_bus_n_if -- bundle of CPU-side and peripheral-side signals of the
// memory-mapped I/O bus.
//   m_addr/m_wdata/m_wr/m_rd    : CPU request (driven by the environment)
//   m_rdata/m_ready/m_err       : CPU response (driven by the bus)
//   s_addr/s_wdata/s_wr/s_rd    : shared slave request and per-slave strobes
//   s_rdata/s_ack               : per-slave read data and completion
// Modports:
//   master : CPU plus peripherals, i.e. everything around the bus
//   slave  : the bus block itself (mio_bus_n)
interface mio_bus_n_if #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int NUM_SLV = 4
);
   logic [ADDR_W-1:0]         m_addr;
   logic [DATA_W-1:0]         m_wdata;
   logic                      m_wr;
   logic                      m_rd;
   logic [DATA_W-1:0]         m_rdata;
   logic                      m_ready;
   logic                      m_err;
   logic [ADDR_W-1:0]         s_addr;
   logic [DATA_W-1:0]         s_wdata;
   logic [NUM_SLV-1:0]        s_wr;
   logic [NUM_SLV-1:0]        s_rd;
   logic [NUM_SLV*DATA_W-1:0] s_rdata;
   logic [NUM_SLV-1:0]        s_ack;

   modport master (
      output m_addr, m_wdata, m_wr, m_rd, s_rdata, s_ack,
      input  m_rdata, m_ready, m_err, s_addr, s_wdata, s_wr, s_rd
   );

   modport slave (
      input  m_addr, m_wdata, m_wr, m_rd, s_rdata, s_ack,
      output m_rdata, m_ready, m_err, s_addr, s_wdata, s_wr, s_rd
   );
endinterface

// File: rtl/mio_bus_n.sv
// mio_bus_n -- memory-mapped I/O bus between the CPU data port and NUM_SLV
// peripherals. The slave is selected by addr[SEL_LSB+3:SEL_LSB]; each access
// holds its strobe until the selected slave acks, so slow slaves can insert
// wait states. Unmapped slave indices complete at once with an error.
// Ports:
//   clk  : system clock, all logic on posedge
//   clrn : asynchronous active-low reset
//   bus  : mio_bus_n_if.slave (CPU request/response and slave channels)
// Configuration macro MIO_TIMEOUT_EN: when defined, an access that sees no ack
// for TMO_CYC cycles is terminated with m_err=1 and m_rdata=16'hDEAD repeated.
// When undefined, an access waits for its ack indefinitely.
module mio_bus_n #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int NUM_SLV = 4,
   parameter int SEL_LSB = 28,
   parameter int TMO_CYC = 15
) (
   input logic        clk,
   input logic        clrn,
   mio_bus_n_if.slave bus
);

   if (NUM_SLV < 1 || NUM_SLV > 16 || TMO_CYC < 1 || TMO_CYC > 255) begin : g_param_chk
      $error("mio_bus_n: NUM_SLV or TMO_CYC out of range");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [DATA_W-1:0] TMO_DATA = {(DATA_W/16){16'hDEAD}};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                op_wr_q, op_wr_d;
   logic [3:0]          idx_q, idx_d;
   logic [NUM_SLV-1:0]  s_wr_q, s_wr_d;
   logic [NUM_SLV-1:0]  s_rd_q, s_rd_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                ready_q, ready_d;

   logic                req_s;
   logic [3:0]          idx_in_s;
   logic                mapped_s;
   logic [NUM_SLV-1:0]  onehot_s;
   logic                ack_sel_s;
   logic [DATA_W-1:0]   rdata_sel_s;
   logic                tmo_hit_s;

   assign req_s    = bus.m_wr | bus.m_rd;
   assign idx_in_s = bus.m_addr[SEL_LSB+3:SEL_LSB];
   assign mapped_s = (int'(idx_in_s) < NUM_SLV);

   // Slave mux: one-hot strobe for the incoming index, ack/rdata of the latched index.
   always_comb begin
      onehot_s    = {NUM_SLV{1'b0}};
      ack_sel_s   = 1'b0;
      rdata_sel_s = {DATA_W{1'b0}};
      for (int k = 0; k < NUM_SLV; k++) begin
         onehot_s[k] = (idx_in_s == 4'(k));
         if (idx_q == 4'(k)) begin
            ack_sel_s   = bus.s_ack[k];
            rdata_sel_s = bus.s_rdata[k*DATA_W +: DATA_W];
         end else begin
            ack_sel_s   = ack_sel_s;
            rdata_sel_s = rdata_sel_s;
         end
      end
   end

`ifdef MIO_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;

   // Terminal count: the last ACCESS cycle allowed without an ack.
   assign tmo_hit_s = (cnt_q == 8'(TMO_CYC - 1));

   // Wait counter: cleared on entry to ACCESS, counts ACCESS cycles without ack.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_IDLE && req_s && mapped_s) begin
         cnt_d = 8'd0;
      end else if (state_q == ST_ACCESS && !ack_sel_s) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Wait counter register.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign tmo_hit_s = 1'b0;
`endif

   // State and registered outputs.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= ST_IDLE;
         addr_q  <= {ADDR_W{1'b0}};
         wdata_q <= {DATA_W{1'b0}};
         op_wr_q <= 1'b0;
         idx_q   <= 4'd0;
         s_wr_q  <= {NUM_SLV{1'b0}};
         s_rd_q  <= {NUM_SLV{1'b0}};
         rdata_q <= {DATA_W{1'b0}};
         err_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         op_wr_q <= op_wr_d;
         idx_q   <= idx_d;
         s_wr_q  <= s_wr_d;
         s_rd_q  <= s_rd_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         ready_q <= ready_d;
      end
   end

   // Next-state logic. An ack in the terminal-count cycle takes precedence over timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               state_d = mapped_s ? ST_ACCESS : ST_RESP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (ack_sel_s || tmo_hit_s) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_ACCESS;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and the latched request.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      op_wr_d = op_wr_q;
      idx_d   = idx_q;
      s_wr_d  = s_wr_q;
      s_rd_d  = s_rd_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      ready_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               addr_d  = bus.m_addr;
               wdata_d = bus.m_wdata;
               op_wr_d = bus.m_wr;
               idx_d   = idx_in_s;
               rdata_d = {DATA_W{1'b0}};
               if (mapped_s) begin
                  // Write wins when both requests are present.
                  s_wr_d = bus.m_wr ? onehot_s : {NUM_SLV{1'b0}};
                  s_rd_d = bus.m_wr ? {NUM_SLV{1'b0}} : onehot_s;
                  err_d  = 1'b0;
               end else begin
                  s_wr_d  = {NUM_SLV{1'b0}};
                  s_rd_d  = {NUM_SLV{1'b0}};
                  err_d   = 1'b1;
                  ready_d = 1'b1;
               end
            end else begin
               ready_d = 1'b0;
            end
         end
         ST_ACCESS: begin
            if (ack_sel_s) begin
               s_wr_d  = {NUM_SLV{1'b0}};
               s_rd_d  = {NUM_SLV{1'b0}};
               rdata_d = op_wr_q ? {DATA_W{1'b0}} : rdata_sel_s;
               err_d   = 1'b0;
               ready_d = 1'b1;
            end else if (tmo_hit_s) begin
               s_wr_d  = {NUM_SLV{1'b0}};
               s_rd_d  = {NUM_SLV{1'b0}};
               rdata_d = TMO_DATA;
               err_d   = 1'b1;
               ready_d = 1'b1;
            end else begin
               ready_d = 1'b0;
            end
         end
         ST_RESP: ready_d = 1'b0;
         default: ready_d = 1'b0;
      endcase
   end

   assign bus.s_addr  = addr_q;
   assign bus.s_wdata = wdata_q;
   assign bus.s_wr    = s_wr_q;
   assign bus.s_rd    = s_rd_q;
   assign bus.m_rdata = rdata_q;
   assign bus.m_err   = err_q;
   assign bus.m_ready = ready_q;

endmodule

// File: tb/tb_mio_bus_n.sv
// Testbench for mio_bus_n (default parameters). A transaction-level model
// derives, from each access's address, opcode and ack timing, the cycle-by-cycle
// strobes, response cycle and response data; one negedge process compares the
// DUT against it. Literal latency/strobe-length/data pins check the model itself.
module tb_mio_bus_n;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int NS  = 4;
   localparam int TMO = 15;

   logic clk  = 1'b0;
   logic clrn = 1'b0;
   int   cyc  = 0;
   int   checks = 0;
   int   failures = 0;

   mio_bus_n_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_SLV(NS)) bus ();

   mio_bus_n #(.DATA_W(DW), .ADDR_W(AW), .NUM_SLV(NS), .SEL_LSB(28), .TMO_CYC(TMO)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // model expectations for the current cycle
   logic          chk_en = 1'b0;
   logic [NS-1:0] exp_wr = '0, exp_rd = '0;
   logic          exp_ready = 1'b0, exp_err = 1'b0, exp_sbus = 1'b0;
   logic [DW-1:0] exp_rdata = '0, exp_swdata = '0;
   logic [AW-1:0] exp_saddr = '0;

   // observations used by the literal pins
   int            req_cyc = 0, obs_lat = -1, obs_str = 0;
   logic [DW-1:0] last_rdata = '0, last_swdata = '0;
   logic          last_err = 1'b0;
   logic [NS-1:0] obs_wr_or = '0, obs_rd_or = '0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("s_wr", 64'(bus.s_wr), 64'(exp_wr));
         check("s_rd", 64'(bus.s_rd), 64'(exp_rd));
         check("m_ready", 64'(bus.m_ready), 64'(exp_ready));
         if (exp_ready) begin
            check("m_rdata", 64'(bus.m_rdata), 64'(exp_rdata));
            check("m_err", 64'(bus.m_err), 64'(exp_err));
         end
         if (exp_sbus) begin
            check("s_addr", 64'(bus.s_addr), 64'(exp_saddr));
            check("s_wdata", 64'(bus.s_wdata), 64'(exp_swdata));
         end
         if (bus.m_ready && obs_lat < 0) begin
            obs_lat    = cyc - req_cyc;
            last_rdata = bus.m_rdata;
            last_err   = bus.m_err;
         end
         if ((|bus.s_wr) || (|bus.s_rd)) begin
            obs_str++;
            last_swdata = bus.s_wdata;
         end
         obs_wr_or = obs_wr_or | bus.s_wr;
         obs_rd_or = obs_rd_or | bus.s_rd;
      end
   end

   task automatic set_idle();
      exp_wr = '0; exp_rd = '0; exp_ready = 1'b0; exp_sbus = 1'b0;
      bus.s_ack = '0;
   endtask

   // One access. ack_k: ACCESS cycle (1-based) in which the slave acks, 0 = never.
   task automatic run_txn(input string nm, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic wr, input logic rd, input int ack_k, input logic [31:0] srd,
                          input int lit_lat, input int lit_str, input logic [31:0] lit_rdata,
                          input logic lit_err);
      logic [3:0]    idx;
      logic [NS-1:0] oh;
      bit            mapped, tmo;
      int            str_len;
      idx    = addr[31:28];
      mapped = (idx < 4'd4);
      oh     = mapped ? (4'b0001 << idx) : 4'b0000;
      tmo    = 1'b0;
      if (!mapped) str_len = 0;
      else begin
`ifdef MIO_TIMEOUT_EN
         if (ack_k == 0 || ack_k > TMO) begin str_len = TMO; tmo = 1'b1; end
         else str_len = ack_k;
`else
         str_len = ack_k;
`endif
      end
      for (int j = 0; j < NS; j++)
         bus.s_rdata[j*DW +: DW] = (j == int'(idx)) ? srd : (32'hBAD0_0000 | 32'(j));
      @(posedge clk); #1;
      req_cyc = cyc; obs_lat = -1; obs_str = 0; obs_wr_or = '0; obs_rd_or = '0;
      bus.m_addr = addr; bus.m_wdata = wdata; bus.m_wr = wr; bus.m_rd = rd;
      set_idle();
      for (int k = 1; k <= str_len + 1; k++) begin
         @(posedge clk); #1;
         if (k <= str_len) begin
            exp_wr = wr ? oh : '0;
            exp_rd = wr ? '0 : oh;
            exp_ready = 1'b0;
            exp_sbus = 1'b1; exp_saddr = addr; exp_swdata = wdata;
            // other slaves' acks are noise that must be ignored
            bus.s_ack = (k == ack_k) ? oh : ~oh;
         end else begin
            set_idle();
            exp_ready = 1'b1;
            exp_err   = !mapped || tmo;
            exp_rdata = !mapped ? 32'h0 : (tmo ? 32'hDEAD_DEAD : (wr ? 32'h0 : srd));
         end
      end
      @(posedge clk); #1;
      bus.m_wr = 1'b0; bus.m_rd = 1'b0;
      set_idle();
      @(posedge clk); #1;
      check({nm, "_lat"}, 64'(obs_lat), 64'(lit_lat));
      check({nm, "_strobe_cycles"}, 64'(obs_str), 64'(lit_str));
      check({nm, "_rdata"}, 64'(last_rdata), 64'(lit_rdata));
      check({nm, "_err"}, 64'(last_err), 64'(lit_err));
   endtask

   initial begin
      bus.m_addr = '0; bus.m_wdata = '0; bus.m_wr = 1'b0; bus.m_rd = 1'b0;
      bus.s_rdata = '0; bus.s_ack = '0;
      #12;
      check("rst_s_wr", 64'(bus.s_wr), 64'h0);
      check("rst_s_rd", 64'(bus.s_rd), 64'h0);
      check("rst_m_ready", 64'(bus.m_ready), 64'h0);
      check("rst_m_err", 64'(bus.m_err), 64'h0);
      check("rst_m_rdata", 64'(bus.m_rdata), 64'h0);
      check("rst_s_addr", 64'(bus.s_addr), 64'h0);
      check("rst_s_wdata", 64'(bus.s_wdata), 64'h0);
      @(posedge clk); #1;
      clrn = 1'b1;
      chk_en = 1'b1;

      // 1: read, slave 1, 3 wait states
      run_txn("t1_read_wait3", 32'h1000_0004, 32'h0, 1'b0, 1'b1, 4, 32'h1234_5678,
              5, 4, 32'h1234_5678, 1'b0);
      // 2: write, slave 0, immediate ack
      run_txn("t2_write", 32'h0000_0010, 32'hCAFE_0001, 1'b1, 1'b0, 1, 32'h1111_2222,
              2, 1, 32'h0, 1'b0);
      check("t2_s_wdata", 64'(last_swdata), 64'hCAFE_0001);
      // 3: unmapped read, idx 7
      run_txn("t3_unmapped", 32'h7000_0000, 32'h0, 1'b0, 1'b1, 1, 32'h0,
              1, 0, 32'h0, 1'b1);
      // boundary indices: first and last unmapped
      run_txn("idx4_unmapped", 32'h4000_0008, 32'h0, 1'b0, 1'b1, 1, 32'h0,
              1, 0, 32'h0, 1'b1);
      run_txn("idxF_unmapped", 32'hF000_0000, 32'h0, 1'b1, 1'b0, 1, 32'h0,
              1, 0, 32'h0, 1'b1);
      // 4: slave 2 does not ack
`ifdef MIO_TIMEOUT_EN
      run_txn("t4_timeout", 32'h2000_0000, 32'h0, 1'b0, 1'b1, 0, 32'h5A5A_5A5A,
              16, 15, 32'hDEAD_DEAD, 1'b1);
      run_txn("t4_ack_at_tc", 32'h2000_0004, 32'h0, 1'b0, 1'b1, 15, 32'h5A5A_5A5A,
              16, 15, 32'h5A5A_5A5A, 1'b0);
`else
      run_txn("t4_no_timeout", 32'h2000_0000, 32'h0, 1'b0, 1'b1, 101, 32'h5A5A_5A5A,
              102, 101, 32'h5A5A_5A5A, 1'b0);
`endif
      // 5: write and read together, slave 3
      run_txn("t5_wr_wins", 32'h3000_0020, 32'h5555_AAAA, 1'b1, 1'b1, 2, 32'h7777_7777,
              3, 2, 32'h0, 1'b0);
      check("t5_s_wr_seen", 64'(obs_wr_or), 64'h8);
      check("t5_s_rd_seen", 64'(obs_rd_or), 64'h0);
      // read of last mapped slave
      run_txn("read_slv3", 32'h3000_0100, 32'h0, 1'b0, 1'b1, 1, 32'hA5A5_0F0F,
              2, 1, 32'hA5A5_0F0F, 1'b0);

      // 6: reset during ACCESS cycle 2
      for (int j = 0; j < NS; j++) bus.s_rdata[j*DW +: DW] = 32'h0;
      @(posedge clk); #1;
      bus.m_addr = 32'h1000_0008; bus.m_rd = 1'b1;
      set_idle();
      @(posedge clk); #1;
      exp_rd = 4'b0010;
      @(posedge clk); #1;
      exp_rd = 4'b0010;
      #2;
      chk_en = 1'b0;
      clrn = 1'b0;
      bus.m_rd = 1'b0;
      #1;
      check("t6_async_s_rd", 64'(bus.s_rd), 64'h0);
      check("t6_async_s_wr", 64'(bus.s_wr), 64'h0);
      check("t6_async_m_ready", 64'(bus.m_ready), 64'h0);
      @(posedge clk); #1;
      check("t6_rst_m_ready", 64'(bus.m_ready), 64'h0);
      clrn = 1'b1;
      set_idle();
      chk_en = 1'b1;
      run_txn("t6_after_reset", 32'h1000_000C, 32'h0, 1'b0, 1'b1, 2, 32'h0BAD_F00D,
              3, 2, 32'h0BAD_F00D, 1'b0);

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
